// File: rtl/wb_dp_bram_gen.sv
// True dual-port block RAM with two independent Wishbone B4 pipelined slave ports (A, B).
// Define WB_DP_BRAM_OUTREG_EN to add an output register per port (latency 2 instead of 1).
module wb_dp_bram_gen #(
    parameter int    DW        = 32,
    parameter int    DEPTH     = 1024,
    parameter string INIT_FILE = "",
    localparam int   AW        = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            a_cyc_i,
    input  logic            a_stb_i,
    input  logic            a_we_i,
    input  logic [AW-1:0]   a_adr_i,
    input  logic [DW-1:0]   a_dat_i,
    input  logic [DW/8-1:0] a_sel_i,
    output logic            a_stall_o,
    output logic            a_ack_o,
    output logic            a_err_o,
    output logic [DW-1:0]   a_dat_o,

    input  logic            b_cyc_i,
    input  logic            b_stb_i,
    input  logic            b_we_i,
    input  logic [AW-1:0]   b_adr_i,
    input  logic [DW-1:0]   b_dat_i,
    input  logic [DW/8-1:0] b_sel_i,
    output logic            b_stall_o,
    output logic            b_ack_o,
    output logic            b_err_o,
    output logic [DW-1:0]   b_dat_o
);
    localparam int          NB      = DW / 8;
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];

    // Index 0 is port A, index 1 is port B.
    logic [1:0]    cyc, stb, we;
    logic [AW-1:0] adr  [2];
    logic [DW-1:0] wdat [2];
    logic [NB-1:0] sel  [2];

    logic [1:0]    req, hit, wr;
    logic [1:0]    ack1_d, ack1_q, err1_d, err1_q;
    logic [DW-1:0] rd1_d [2];
    logic [DW-1:0] rd1_q [2];

    logic [1:0]    rsp_ack, rsp_err;
    logic [DW-1:0] rsp_dat [2];

    assign cyc     = {b_cyc_i, a_cyc_i};
    assign stb     = {b_stb_i, a_stb_i};
    assign we      = {b_we_i, a_we_i};
    assign adr[0]  = a_adr_i;
    assign adr[1]  = b_adr_i;
    assign wdat[0] = a_dat_i;
    assign wdat[1] = b_dat_i;
    assign sel[0]  = a_sel_i;
    assign sel[1]  = b_sel_i;

    // NOTE: every output of an always_comb is assigned on every path, so no latch is inferred.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            req[p]    = cyc[p] & stb[p];
            hit[p]    = {1'b0, adr[p]} < DEPTH_W;
            wr[p]     = req[p] & hit[p] & we[p];
            ack1_d[p] = req[p] & hit[p];
            err1_d[p] = req[p] & ~hit[p];
            // Reads and writes both capture the pre-write word; errors leave the data alone.
            rd1_d[p]  = ack1_d[p] ? mem[adr[p]] : rd1_q[p];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack1_q <= '0;
            err1_q <= '0;
            rd1_q  <= '{default: '0};
        end else begin
            ack1_q <= ack1_d;
            err1_q <= err1_d;
            rd1_q  <= rd1_d;
        end
    end

    // NOTE: the memory array has no reset; its contents survive reset and it maps onto block RAM.
    // Port B lanes are scheduled first so a lane both ports select ends up with port A's byte.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (wr[1] && sel[1][i]) mem[adr[1]][i*8 +: 8] <= wdat[1][i*8 +: 8];
            if (wr[0] && sel[0][i]) mem[adr[0]][i*8 +: 8] <= wdat[0][i*8 +: 8];
        end
    end

`ifdef WB_DP_BRAM_OUTREG_EN
    logic [1:0]    ack2_d, ack2_q, err2_d, err2_q;
    logic [DW-1:0] rd2_d [2];
    logic [DW-1:0] rd2_q [2];

    // A response still in the first stage is dropped if its master has released cyc.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            ack2_d[p] = ack1_q[p] & cyc[p];
            err2_d[p] = err1_q[p] & cyc[p];
            rd2_d[p]  = ack2_d[p] ? rd1_q[p] : rd2_q[p];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack2_q <= '0;
            err2_q <= '0;
            rd2_q  <= '{default: '0};
        end else begin
            ack2_q <= ack2_d;
            err2_q <= err2_d;
            rd2_q  <= rd2_d;
        end
    end

    assign rsp_ack = ack2_q;
    assign rsp_err = err2_q;
    assign rsp_dat = rd2_q;
`else
    assign rsp_ack = ack1_q;
    assign rsp_err = err1_q;
    assign rsp_dat = rd1_q;
`endif

    assign a_stall_o = 1'b0;
    assign b_stall_o = 1'b0;
    assign a_ack_o   = rsp_ack[0];
    assign b_ack_o   = rsp_ack[1];
    assign a_err_o   = rsp_err[0];
    assign b_err_o   = rsp_err[1];
    assign a_dat_o   = rsp_dat[0];
    assign b_dat_o   = rsp_dat[1];

endmodule

// File: tb/tb_wb_dp_bram_gen.sv
// Self-checking bench for wb_dp_bram_gen: directed scenarios plus random dual-port traffic,
// scored every cycle against a word-array model with a queue of expected responses per port.
module tb_wb_dp_bram_gen;
    localparam int DW    = 32;
    localparam int DEPTH = 1000;
    localparam int AW    = $clog2(DEPTH);
    localparam int NB    = DW / 8;
`ifdef WB_DP_BRAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        int            due;
        bit            err;
        bit            dk;
        logic [DW-1:0] dat;
    } resp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [1:0]    cyc, stb, we, ack, err, stall;
    logic [AW-1:0] adr  [2];
    logic [DW-1:0] wdat [2];
    logic [DW-1:0] rdat [2];
    logic [NB-1:0] sel  [2];

    logic [DW-1:0] model_mem [DEPTH];
    bit            known [DEPTH];
    resp_t         qa[$];
    resp_t         qb[$];
    logic [DW-1:0] last_dat [2];
    bit            last_known [2];
    int            acks_seen [2];
    int            step;
    int            checks;
    int            errors;

    always #5 clk = ~clk;

    wb_dp_bram_gen #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .a_cyc_i   (cyc[0]),
        .a_stb_i   (stb[0]),
        .a_we_i    (we[0]),
        .a_adr_i   (adr[0]),
        .a_dat_i   (wdat[0]),
        .a_sel_i   (sel[0]),
        .a_stall_o (stall[0]),
        .a_ack_o   (ack[0]),
        .a_err_o   (err[0]),
        .a_dat_o   (rdat[0]),
        .b_cyc_i   (cyc[1]),
        .b_stb_i   (stb[1]),
        .b_we_i    (we[1]),
        .b_adr_i   (adr[1]),
        .b_dat_i   (wdat[1]),
        .b_sel_i   (sel[1]),
        .b_stall_o (stall[1]),
        .b_ack_o   (ack[1]),
        .b_err_o   (err[1]),
        .b_dat_o   (rdat[1])
    );

    initial begin
        #200000;
        $display("FAIL watchdog step=%0d simulation did not finish in time", step);
        $fatal(1, "watchdog expired");
    end

    task automatic set_port(input int p, input bit c, input bit s, input bit w, input int a,
                            input logic [DW-1:0] d, input logic [NB-1:0] sl);
        cyc[p]  = c;
        stb[p]  = s;
        we[p]   = w;
        adr[p]  = AW'(a);
        wdat[p] = d;
        sel[p]  = sl;
    endtask

    task automatic idle_both();
        set_port(0, 1'b1, 1'b0, 1'b0, 0, '0, '0);
        set_port(1, 1'b1, 1'b0, 1'b0, 0, '0, '0);
    endtask

    function automatic bit writes(input int p);
        return cyc[p] && stb[p] && we[p] && (int'(adr[p]) < DEPTH);
    endfunction

    // Model: queue the response each accepted request must produce, then apply the writes.
    task automatic commit();
        resp_t r;
        int    aa, ab;
        if (!cyc[0]) qa.delete();
        if (!cyc[1]) qb.delete();
        for (int p = 0; p < 2; p++) begin
            if (cyc[p] && stb[p]) begin
                r.due = step + LAT;
                r.err = int'(adr[p]) >= DEPTH;
                r.dk  = 1'b0;
                r.dat = '0;
                if (!r.err) begin
                    r.dk  = known[adr[p]];
                    r.dat = model_mem[adr[p]];
                end
                if (p == 0) qa.push_back(r);
                else        qb.push_back(r);
            end
        end
        aa = int'(adr[0]);
        ab = int'(adr[1]);
        if (writes(1)) begin
            for (int i = 0; i < NB; i++)
                if (sel[1][i] && !(writes(0) && aa == ab && sel[0][i]))
                    model_mem[ab][i*8 +: 8] = wdat[1][i*8 +: 8];
            if (&sel[1]) known[ab] = 1'b1;
        end
        if (writes(0)) begin
            for (int i = 0; i < NB; i++)
                if (sel[0][i]) model_mem[aa][i*8 +: 8] = wdat[0][i*8 +: 8];
            if (&sel[0]) known[aa] = 1'b1;
        end
    endtask

    // Monitor: on each falling edge compare both ports with whatever response is due now.
    task automatic tick();
        resp_t r [2];
        bit    has [2];
        logic  exp_ack, exp_err;
        @(negedge clk);
        step++;
        has[0] = qa.size() > 0 && qa[0].due == step;
        has[1] = qb.size() > 0 && qb[0].due == step;
        if (has[0]) r[0] = qa.pop_front();
        if (has[1]) r[1] = qb.pop_front();
        for (int p = 0; p < 2; p++) begin
            exp_ack = has[p] && !r[p].err;
            exp_err = has[p] && r[p].err;
            if (exp_ack) begin
                last_dat[p]   = r[p].dat;
                last_known[p] = r[p].dk;
            end
            checks++;
            if (ack[p] !== exp_ack || err[p] !== exp_err) begin
                errors++;
                $display("FAIL resp_p%0d step=%0d ack,err got=%b,%b expected=%b,%b",
                         p, step, ack[p], err[p], exp_ack, exp_err);
            end
            if (last_known[p]) begin
                checks++;
                if (rdat[p] !== last_dat[p]) begin
                    errors++;
                    $display("FAIL dat_p%0d step=%0d got=%h expected=%h", p, step, rdat[p], last_dat[p]);
                end
            end
            if (ack[p] === 1'b1) acks_seen[p]++;
        end
    endtask

    task automatic cycle();
        commit();
        tick();
    endtask

    task automatic drain();
        idle_both();
        repeat (LAT + 1) cycle();
    endtask

    task automatic read_expect(input int p, input int a, input logic [DW-1:0] exp, input string name);
        idle_both();
        set_port(p, 1'b1, 1'b1, 1'b0, a, '0, '0);
        cycle();
        idle_both();
        repeat (LAT - 1) cycle();
        checks++;
        if (ack[p] !== 1'b1 || rdat[p] !== exp) begin
            errors++;
            $display("FAIL %s ack=%b dat=%h expected ack=1 dat=%h", name, ack[p], rdat[p], exp);
        end
        cycle();
    endtask

    task automatic test_reset();
        set_port(0, 1'b0, 1'b0, 1'b0, 0, '0, '0);
        set_port(1, 1'b0, 1'b0, 1'b0, 0, '0, '0);
        last_dat   = '{default: '0};
        last_known = '{default: 1'b1};
        #1 reset = 1'b1;
        #1;
        checks++;
        if (ack !== 2'b00 || err !== 2'b00 || stall !== 2'b00 || rdat[0] !== '0 || rdat[1] !== '0) begin
            errors++;
            $display("FAIL reset_state ack=%b err=%b stall=%b dat_a=%h dat_b=%h expected all zero",
                     ack, err, stall, rdat[0], rdat[1]);
        end
        tick();
        tick();
        reset = 1'b0;
        idle_both();
        cycle();
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH / 2; i++) begin
            set_port(0, 1'b1, 1'b1, 1'b1, i, $urandom, '1);
            set_port(1, 1'b1, 1'b1, 1'b1, DEPTH - 1 - i, $urandom, '1);
            cycle();
        end
        drain();
    endtask

    task automatic test_basic();
        idle_both();
        set_port(0, 1'b1, 1'b1, 1'b1, 'h010, 32'hDEADBEEF, 4'hF);
        cycle();
        idle_both();
        set_port(1, 1'b1, 1'b1, 1'b0, 'h010, '0, '0);
        cycle();
        idle_both();
        repeat (LAT - 1) cycle();
        checks++;
        if (ack[1] !== 1'b1 || rdat[1] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL basic_b_read ack=%b dat=%h expected ack=1 dat=deadbeef", ack[1], rdat[1]);
        end
        drain();
        // A write hands back the word it replaces.
        set_port(0, 1'b1, 1'b1, 1'b1, 'h010, 32'h01234567, 4'hF);
        cycle();
        idle_both();
        repeat (LAT - 1) cycle();
        checks++;
        if (ack[0] !== 1'b1 || rdat[0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_old_word ack=%b dat=%h expected ack=1 dat=deadbeef", ack[0], rdat[0]);
        end
        drain();
    endtask

    task automatic test_byte_lanes();
        idle_both();
        set_port(0, 1'b1, 1'b1, 1'b1, 5, 32'h11223344, 4'hF);
        cycle();
        set_port(0, 1'b1, 1'b1, 1'b1, 5, 32'hAABBCCDD, 4'b0101);
        cycle();
        set_port(0, 1'b1, 1'b1, 1'b1, 5, 32'hFFFFFFFF, 4'b0000);
        cycle();
        drain();
        read_expect(0, 5, 32'h11BB33DD, "byte_lane_merge");
    endtask

    task automatic test_collision();
        logic [DW-1:0] old9;
        set_port(0, 1'b1, 1'b1, 1'b1, 7, 32'h11111111, 4'hF);
        set_port(1, 1'b1, 1'b1, 1'b1, 7, 32'h22222222, 4'hF);
        cycle();
        set_port(0, 1'b1, 1'b1, 1'b1, 8, 32'hAAAAAAAA, 4'b0011);
        set_port(1, 1'b1, 1'b1, 1'b1, 8, 32'hBBBBBBBB, 4'b1110);
        cycle();
        drain();
        read_expect(1, 7, 32'h11111111, "collision_full");
        read_expect(0, 8, 32'hBBBBAAAA, "collision_lanes");
        old9 = model_mem[9];
        set_port(0, 1'b1, 1'b1, 1'b1, 9, 32'h5A5A5A5A, 4'hF);
        set_port(1, 1'b1, 1'b1, 1'b0, 9, '0, '0);
        cycle();
        idle_both();
        repeat (LAT - 1) cycle();
        checks++;
        if (ack[1] !== 1'b1 || rdat[1] !== old9) begin
            errors++;
            $display("FAIL cross_read_first ack=%b dat=%h expected ack=1 dat=%h", ack[1], rdat[1], old9);
        end
        drain();
        read_expect(1, 9, 32'h5A5A5A5A, "cross_write_landed");
    endtask

    task automatic test_out_of_range();
        logic [DW-1:0] w999;
        w999 = model_mem[DEPTH - 1];
        read_expect(0, DEPTH - 1, w999, "read_last_word");
        set_port(0, 1'b1, 1'b1, 1'b0, DEPTH, '0, '0);
        cycle();
        idle_both();
        repeat (LAT - 1) cycle();
        checks++;
        if (err[0] !== 1'b1 || ack[0] !== 1'b0 || rdat[0] !== w999) begin
            errors++;
            $display("FAIL oor_read err=%b ack=%b dat=%h expected err=1 ack=0 dat=%h",
                     err[0], ack[0], rdat[0], w999);
        end
        set_port(0, 1'b1, 1'b1, 1'b1, DEPTH, 32'hCAFEF00D, 4'hF);
        cycle();
        set_port(0, 1'b1, 1'b1, 1'b1, (1 << AW) - 1, 32'h0BADF00D, 4'hF);
        cycle();
        drain();
        read_expect(0, DEPTH - 1, w999, "oor_write_no_effect");
    endtask

    task automatic test_back_to_back();
        int  base;
        bit  dropped;
        base = acks_seen[0];
        for (int k = 0; k < 8; k++) begin
            idle_both();
            set_port(0, 1'b1, 1'b1, 1'b0, k, '0, '0);
            cycle();
        end
        drain();
        checks++;
        if (acks_seen[0] - base != 8) begin
            errors++;
            $display("FAIL burst_ack_count got=%0d expected=8", acks_seen[0] - base);
        end
        base    = acks_seen[0];
        dropped = 1'b0;
        for (int k = 0; k < 20 && !dropped; k++) begin
            set_port(0, 1'b1, 1'b1, 1'b0, k, '0, '0);
            cycle();
            if (acks_seen[0] - base >= 4) begin
                set_port(0, 1'b0, 1'b0, 1'b0, 0, '0, '0);
                dropped = 1'b1;
            end
        end
        checks++;
        if (!dropped) begin
            errors++;
            $display("FAIL burst_drop_timeout acks=%0d expected 4 within 20 cycles", acks_seen[0] - base);
        end
        repeat (6) cycle();
        checks++;
        if (acks_seen[0] - base != 4) begin
            errors++;
            $display("FAIL burst_squash acks=%0d expected=4", acks_seen[0] - base);
        end
        drain();
    endtask

    task automatic test_reset_midburst();
        logic [DW-1:0] v0, v1;
        v0 = model_mem[0];
        v1 = model_mem[1];
        idle_both();
        set_port(0, 1'b1, 1'b1, 1'b0, 0, '0, '0);
        cycle();
        set_port(0, 1'b1, 1'b1, 1'b0, 1, '0, '0);
        cycle();
        set_port(0, 1'b1, 1'b1, 1'b0, 2, '0, '0);
        commit();
        @(posedge clk);
        #2;
        checks++;
        if (ack[0] !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_ack got=%b expected=1", ack[0]);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (ack !== 2'b00 || err !== 2'b00 || rdat[0] !== '0 || rdat[1] !== '0) begin
            errors++;
            $display("FAIL reset_midburst ack=%b err=%b dat_a=%h dat_b=%h expected all zero",
                     ack, err, rdat[0], rdat[1]);
        end
        qa.delete();
        qb.delete();
        last_dat   = '{default: '0};
        last_known = '{default: 1'b1};
        set_port(0, 1'b0, 1'b0, 1'b0, 0, '0, '0);
        set_port(1, 1'b0, 1'b0, 1'b0, 0, '0, '0);
        tick();
        tick();
        reset = 1'b0;
        idle_both();
        cycle();
        read_expect(0, 0, v0, "post_reset_read_a");
        read_expect(1, 1, v1, "post_reset_read_b");
    endtask

    task automatic test_random();
        int a, r;
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < 2; p++) begin
                r = $urandom_range(0, 9);
                if (r < 5)      a = $urandom_range(0, 15);
                else if (r < 8) a = $urandom_range(0, DEPTH - 1);
                else            a = $urandom_range(DEPTH - 8, (1 << AW) - 1);
                set_port(p, $urandom_range(0, 31) != 0, $urandom_range(0, 3) != 0,
                         1'($urandom_range(0, 1)), a, $urandom, NB'($urandom_range(0, 15)));
            end
            cycle();
        end
        drain();
    endtask

    initial begin
        step       = 0;
        checks     = 0;
        errors     = 0;
        acks_seen  = '{default: 0};
        test_reset();
        test_fill();
        test_basic();
        test_byte_lanes();
        test_collision();
        test_out_of_range();
        test_back_to_back();
        test_reset_midburst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
